// File: rtl/turbo_pkg.sv
// Shared types for the turbo encoder: FSM states, soft-word constants, the interleaver index function.
// Pure declarations; no latency, no flow control.
package turbo_pkg;

    typedef enum logic [1:0] {IDLE, ENCODE, TAIL, DONE} state_e;

    localparam int LLR_MAX_BITS = 64;
    typedef logic [LLR_MAX_BITS-1:0] llr_t;
    typedef llr_t [1:0] llr_sym_t;

    localparam llr_t SINGLE_POS = 64'h0000_0000_3F80_0000;
    localparam llr_t SINGLE_NEG = 64'h0000_0000_BF80_0000;
    localparam llr_t DOUBLE_POS = 64'h3FF0_0000_0000_0000;
    localparam llr_t DOUBLE_NEG = 64'hBFF0_0000_0000_0000;

    // Bit 0 maps to +1.0 and bit 1 to -1.0 in the selected floating-point format.
    function automatic llr_t map_bit(input logic b, input logic dbl);
        if (dbl) return b ? DOUBLE_NEG : DOUBLE_POS;
        return b ? SINGLE_NEG : SINGLE_POS;
    endfunction

    function automatic int pi_idx(input int k, input int n, input int p);
        return (p * k) % n;
    endfunction

endpackage

// File: rtl/rsc_encoder.sv
// Rate-1/2 recursive systematic convolutional encoder (feedback 7, feedforward 5).
// Combinational outputs from the current state; state advances on step or tail, no backpressure.
module rsc_encoder (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic step,
    input  logic tail,
    input  logic u_in,
    output logic sys_out,
    output logic par_out
);

    logic s1_q, s2_q;
    logic s1_d, s2_d;
    logic a;

    always_comb begin
        // During termination the input cancels the feedback so the register drains to 00.
        sys_out = tail ? (s1_q ^ s2_q) : u_in;
        a       = sys_out ^ s1_q ^ s2_q;
        par_out = a ^ s2_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        if (clear) begin
            s1_d = 1'b0;
            s2_d = 1'b0;
        end else if (step || tail) begin
            s1_d = a;
            s2_d = s1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

endmodule

// File: rtl/turbo_encoder.sv
// Block turbo encoder: two RSCs plus (P*k mod N) interleaver; out_valid N+2 clocks after accept (N if
// TURBO_ENCODER_TAIL_EN is undefined); one block in flight, outputs held until out_ready.
module turbo_encoder
    import turbo_pkg::*;
#(
    parameter int BITS            = 32,
    parameter     PRECISION       = "SINGLE",
    parameter int N               = 10,
    parameter int P               = 3,
    parameter int BITS_PER_SYMBOL = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [N-1:0]                               data_in,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [BITS_PER_SYMBOL-1:0][N-1:0][BITS-1:0] encoder1_data_out,
    output logic [BITS_PER_SYMBOL-1:0][N-1:0][BITS-1:0] encoder2_data_out,
    output logic [BITS_PER_SYMBOL-1:0][1:0][BITS-1:0]   tail1_out,
    output logic [BITS_PER_SYMBOL-1:0][1:0][BITS-1:0]   tail2_out,
    output logic [N-1:0]                               result
);

    localparam int   KW  = $clog2(N);
    localparam logic DBL = (PRECISION == "DOUBLE");

    typedef logic [BITS_PER_SYMBOL-1:0][N-1:0][BITS-1:0] blk_t;
    typedef logic [BITS_PER_SYMBOL-1:0][1:0][BITS-1:0]   tl_t;

    function automatic logic [BITS-1:0] mw(input logic b);
        llr_t w;
        w = map_bit(b, DBL);
        return w[BITS-1:0];
    endfunction

    state_e       state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [N-1:0] data_q, data_d;
    logic         out_valid_q, out_valid_d;
    blk_t         enc1_q, enc1_d, enc2_q, enc2_d;
    logic [KW-1:0] pk;
    logic         clear, step, tail_step;
    logic         sys1, par1, sys2, par2;
`ifdef TURBO_ENCODER_TAIL_EN
    tl_t          tail1_q, tail1_d, tail2_q, tail2_d;
`endif

    assign pk = KW'(pi_idx(int'(k_q), N, P));

    rsc_encoder u_rsc1 (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .step   (step),
        .tail   (tail_step),
        .u_in   (data_q[k_q]),
        .sys_out(sys1),
        .par_out(par1)
    );

    rsc_encoder u_rsc2 (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .step   (step),
        .tail   (tail_step),
        .u_in   (data_q[pk]),
        .sys_out(sys2),
        .par_out(par2)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        enc1_d      = enc1_q;
        enc2_d      = enc2_q;
        clear       = 1'b0;
        step        = 1'b0;
        tail_step   = 1'b0;
`ifdef TURBO_ENCODER_TAIL_EN
        tail1_d     = tail1_q;
        tail2_d     = tail2_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    clear   = 1'b1;
                    k_d     = '0;
                    state_d = ENCODE;
                end
            end
            ENCODE: begin
                step            = 1'b1;
                enc1_d[0][k_q]  = mw(sys1);
                enc1_d[1][k_q]  = mw(par1);
                enc2_d[0][k_q]  = mw(sys2);
                enc2_d[1][k_q]  = mw(par2);
                if (k_q == KW'(N - 1)) begin
                    k_d = '0;
`ifdef TURBO_ENCODER_TAIL_EN
                    state_d = TAIL;
`else
                    state_d     = DONE;
                    out_valid_d = 1'b1;
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
`ifdef TURBO_ENCODER_TAIL_EN
            TAIL: begin
                tail_step            = 1'b1;
                tail1_d[0][k_q[0]]   = mw(sys1);
                tail1_d[1][k_q[0]]   = mw(par1);
                tail2_d[0][k_q[0]]   = mw(sys2);
                tail2_d[1][k_q[0]]   = mw(par2);
                if (k_q[0]) begin
                    k_d         = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
`endif
            DONE: begin
                // Returning to IDLE first guarantees no accept on the handshake cycle.
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            enc1_q      <= '0;
            enc2_q      <= '0;
`ifdef TURBO_ENCODER_TAIL_EN
            tail1_q     <= '0;
            tail2_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            enc1_q      <= enc1_d;
            enc2_q      <= enc2_d;
`ifdef TURBO_ENCODER_TAIL_EN
            tail1_q     <= tail1_d;
            tail2_q     <= tail2_d;
`endif
        end
    end

    assign in_ready          = (state_q == IDLE);
    assign out_valid         = out_valid_q;
    assign encoder1_data_out = enc1_q;
    assign encoder2_data_out = enc2_q;
    assign result            = data_q;
`ifdef TURBO_ENCODER_TAIL_EN
    assign tail1_out = tail1_q;
    assign tail2_out = tail2_q;
`else
    assign tail1_out = '0;
    assign tail2_out = '0;
`endif

endmodule

// File: tb/tb_turbo_encoder.sv
// Self-checking bench for turbo_encoder (default parameters, either tail build).
module tb_turbo_encoder;

`ifdef TURBO_ENCODER_TAIL_EN
    localparam int  LAT     = 12;
    localparam bit  TAIL_ON = 1'b1;
`else
    localparam int  LAT     = 10;
    localparam bit  TAIL_ON = 1'b0;
`endif

    typedef logic [1:0][9:0][31:0] blk_t;
    typedef logic [1:0][1:0][31:0] tl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] data_in;
    logic       out_valid;
    logic       out_ready;
    blk_t       enc1, enc2;
    tl_t        tail1, tail2;
    logic [9:0] result;

    int total = 0;
    int bad   = 0;

    turbo_encoder dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .data_in          (data_in),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .encoder1_data_out(enc1),
        .encoder2_data_out(enc2),
        .tail1_out        (tail1),
        .tail2_out        (tail2),
        .result           (result)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mapw(input logic b);
        return b ? 32'hBF80_0000 : 32'h3F80_0000;
    endfunction

    function automatic logic [9:0] interleave(input logic [9:0] d);
        logic [9:0] r;
        for (int k = 0; k < 10; k++) r[k] = d[(3 * k) % 10];
        return r;
    endfunction

    // Reference RSC: a = u ^ s1 ^ s2, parity = a ^ s2, (s1,s2) <= (a,s1); tail input u = s1 ^ s2.
    function automatic void rsc_model(input logic [9:0] u, output logic [9:0] p,
                                      output logic [1:0] ts, output logic [1:0] tp);
        logic s1, s2, a, ut;
        s1 = 1'b0;
        s2 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            a    = u[k] ^ s1 ^ s2;
            p[k] = a ^ s2;
            s2   = s1;
            s1   = a;
        end
        for (int t = 0; t < 2; t++) begin
            ut    = s1 ^ s2;
            a     = ut ^ s1 ^ s2;
            ts[t] = ut;
            tp[t] = a ^ s2;
            s2    = s1;
            s1    = a;
        end
    endfunction

    function automatic blk_t build_blk(input logic [9:0] u, input logic [9:0] p);
        blk_t r;
        for (int k = 0; k < 10; k++) begin
            r[0][k] = mapw(u[k]);
            r[1][k] = mapw(p[k]);
        end
        return r;
    endfunction

    function automatic tl_t build_tail(input logic [1:0] ts, input logic [1:0] tp);
        tl_t r;
        r = '0;
        if (TAIL_ON) begin
            for (int t = 0; t < 2; t++) begin
                r[0][t] = mapw(ts[t]);
                r[1][t] = mapw(tp[t]);
            end
        end
        return r;
    endfunction

    task automatic check_outputs(input string tag, input logic [9:0] d,
                                 input logic [9:0] p1, input logic [9:0] p2,
                                 input logic [1:0] t1s, input logic [1:0] t1p,
                                 input logic [1:0] t2s, input logic [1:0] t2p);
        chk({tag, "_enc1"},   enc1,   build_blk(d, p1));
        chk({tag, "_enc2"},   enc2,   build_blk(interleave(d), p2));
        chk({tag, "_tail1"},  tail1,  build_tail(t1s, t1p));
        chk({tag, "_tail2"},  tail2,  build_tail(t2s, t2p));
        chk({tag, "_result"}, result, d);
    endtask

    task automatic send(input string tag, input logic [9:0] d);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        data_in  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int cyc;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) break;
        end
        chk({tag, "_latency"}, cyc, LAT);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_hs_valid"}, out_valid, 0);
        chk({tag, "_hs_idle"},  in_ready,  1);
    endtask

    typedef struct {
        logic [9:0] d;
        logic [9:0] p;
        logic [1:0] ts;
        logic [1:0] tp;
    } vec_t;

    initial begin
        vec_t       tbl [3];
        logic [9:0] d, p1, p2;
        logic [1:0] t1s, t1p, t2s, t2p;
        int         hold, vcnt;

        // Hand-derived vectors; each input interleaves to an identical sequence so both encoders agree.
        tbl[0] = '{d: 10'b0000000000, p: 10'b0000000000, ts: 2'b00, tp: 2'b00};
        tbl[1] = '{d: 10'b0000000001, p: 10'b0110110111, ts: 2'b11, tp: 2'b10};
        tbl[2] = '{d: 10'b1111111111, p: 10'b1101101101, ts: 2'b11, tp: 2'b10};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        #1;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_enc1",      enc1,      0);
        chk("rst_enc2",      enc2,      0);
        chk("rst_tails",     {tail1, tail2}, 0);
        chk("rst_result",    result,    0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            send($sformatf("tbl%0d", i), tbl[i].d);
            wait_valid($sformatf("tbl%0d", i));
            check_outputs($sformatf("tbl%0d", i), tbl[i].d, tbl[i].p, tbl[i].p,
                          tbl[i].ts, tbl[i].tp, tbl[i].ts, tbl[i].tp);
            handshake($sformatf("tbl%0d", i));
        end

        // Stall in DONE with a competing in_valid that must be ignored.
        d = 10'h2A5;
        rsc_model(d, p1, t1s, t1p);
        rsc_model(interleave(d), p2, t2s, t2p);
        send("stall", d);
        wait_valid("stall");
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            data_in  = ~d;
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", c), out_valid, 1);
            chk($sformatf("stall%0d_ready", c), in_ready,  0);
            check_outputs($sformatf("stall%0d", c), d, p1, p2, t1s, t1p, t2s, t2p);
        end
        handshake("stall");
        chk("stall_no_accept_result", result, d);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Abort with an asynchronous reset while encoding symbol k=4.
        send("abort", 10'h3C9);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_in_ready",  in_ready,  1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_enc1",      enc1,      0);
        chk("abort_enc2",      enc2,      0);
        chk("abort_result",    result,    0);
        #2;
        reset = 1'b0;
        vcnt = 0;
        repeat (LAT + 5) begin
            @(posedge clk);
            #1;
            if (out_valid) vcnt++;
        end
        chk("abort_no_valid", vcnt, 0);
        send("post_abort", tbl[1].d);
        wait_valid("post_abort");
        check_outputs("post_abort", tbl[1].d, tbl[1].p, tbl[1].p,
                      tbl[1].ts, tbl[1].tp, tbl[1].ts, tbl[1].tp);
        handshake("post_abort");

        for (int r = 0; r < 20; r++) begin
            d = 10'($urandom_range(0, 1023));
            rsc_model(d, p1, t1s, t1p);
            rsc_model(interleave(d), p2, t2s, t2p);
            send($sformatf("rnd%0d", r), d);
            wait_valid($sformatf("rnd%0d", r));
            hold = $urandom_range(0, 3);
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            check_outputs($sformatf("rnd%0d", r), d, p1, p2, t1s, t1p, t2s, t2p);
            handshake($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/turbo_encoder.md
TURBO_ENCODER -- requirements
Module: turbo_encoder

Interface
REQ-001 SHALL have parameter BITS, default 32, width of one soft output word.
REQ-002 SHALL have parameter PRECISION, default "SINGLE", soft word format ("SINGLE" for BITS=32, "DOUBLE" for BITS=64).
REQ-003 SHALL have parameter N, default 10, information bits per block.
REQ-004 SHALL have parameter P, default 3, prime interleaver step, coprime with N.
REQ-005 SHALL have parameter BITS_PER_SYMBOL, default 2 (systematic, parity).
REQ-006 SHALL have ports: clk, input, 1, single clock, rising edge.
REQ-007 reset, input, 1: asynchronous, active-high.
REQ-008 in_valid, input, 1: data_in is valid.
REQ-009 in_ready, output, 1: block accepted when in_valid && in_ready.
REQ-010 data_in, input, logic [N]: information bits.
REQ-011 out_valid, output, 1: output block valid.
REQ-012 out_ready, input, 1: consumer accepts the block.
REQ-013 encoder1_data_out, output, [BITS_PER_SYMBOL][N] x BITS: [0][k]=map(u[k]), [1][k]=map(p1[k]).
REQ-014 encoder2_data_out, output, [BITS_PER_SYMBOL][N] x BITS: [0][k]=map(u[pi(k)]), [1][k]=map(p2[k]).
REQ-015 tail1_out and tail2_out, output, [BITS_PER_SYMBOL][2] x BITS: termination symbols per constituent encoder.
REQ-016 result, output, logic [N]: hard copy of the accepted data_in, for BER checking.

Function
REQ-017 SHALL use interleaver pi(k) = (P*k) mod N; N=10, P=3 gives 0,3,6,9,2,5,8,1,4,7.
REQ-018 Each constituent RSC: feedback 7, feedforward 5, state (s1,s2); a=u^s1^s2; p=a^s2; next (s1,s2)=(a,s1).
REQ-019 map(b): b=0 -> +1.0, b=1 -> -1.0 (SINGLE 0x3F800000/0xBF800000; DOUBLE 0x3FF0000000000000/0xBFF0000000000000).
REQ-020 FSM states: IDLE, ENCODE, TAIL, DONE; in_ready = (state==IDLE), combinational.
REQ-021 IDLE: on in_valid, capture data_in and result, clear both RSC states, k=0, go to ENCODE.
REQ-022 ENCODE: one symbol k per clock for both encoders; after k=N-1 go to TAIL (or DONE if tail is compiled out).
REQ-023 TAIL: two clocks with u=s1^s2 per encoder so that a=0; both states end at 00; then go to DONE.
REQ-024 DONE: out_valid=1, all outputs held stable until out_ready; on out_valid&&out_ready go to IDLE next clock.
REQ-025 Latency: out_valid rises N+2 clocks after the accept edge with tail compiled in, N clocks without.
REQ-026 in_valid outside IDLE is ignored. A new block is never accepted in the same cycle as the DONE handshake.

Reset
REQ-027 Reset SHALL asynchronously force IDLE, out_valid=0, RSC states 00, k=0.
REQ-028 Reset SHALL clear all soft outputs to all-zero words and clear result.
REQ-029 in_ready SHALL be 1 while in reset.
REQ-030 Reset mid-ENCODE/TAIL/DONE SHALL abort the block with no out_valid pulse.

Configuration
REQ-031 Macro TURBO_ENCODER_TAIL_EN defined: TAIL state present; tail ports carry map(u_tail) and map(p_tail).
REQ-032 Macro TURBO_ENCODER_TAIL_EN undefined: TAIL skipped; tail ports driven to zero words; final RSC states left unterminated.

Structure
REQ-033 Package turbo_pkg SHALL hold: the state enum, the llr array typedef, the map constants per PRECISION, and a pi(k) function.
REQ-034 Sub-module rsc_encoder (state register, step, and tail inputs) SHALL be instantiated twice.

Verification
REQ-035 All-zero data_in, tail on -> every output word 0x3F800000, out_valid 12 clocks after accept.
REQ-036 u[0]=1, others 0 -> p1 = p2 = 1,1,1,0,1,1,0,1,1,0 (mapped); tail1 systematic 1,1, parity 0,1.
REQ-037 out_ready held low 5 cycles in DONE -> outputs stable, in_valid ignored; handshake -> IDLE next clock.
REQ-038 reset asserted during ENCODE at k=4 -> immediate IDLE, outputs zero, no out_valid; next block encodes correctly.
REQ-039 Macro undefined, same stimulus as REQ-036 -> identical data outputs, tail ports zero, out_valid 10 clocks after accept.
REQ-040 Loopback: outputs fed to soft_in_soft_out with zero extrinsic -> its result equals data_in.
